// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: NUM_M-master / NUM_S-slave RIB interconnect.
// Registered round-robin grant, burst cap with forced rotation, decode error.
module rib_rr_arbiter #(
    parameter int NUM_M     = 3,
    parameter int NUM_S     = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_M-1:0]         m_req_i,
    input  logic [NUM_M-1:0]         m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]  m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]  m_wdata_i,
    output logic [NUM_M*DATA_W-1:0]  m_rdata_o,
    output logic [NUM_M-1:0]         m_ack_o,
    output logic [NUM_M-1:0]         m_err_o,
    output logic [NUM_M-1:0]         m_hold_o,
    output logic [NUM_S-1:0]         s_wr_en_o,
    output logic [NUM_S*ADDR_W-1:0]  s_wr_addr_o,
    output logic [NUM_S*DATA_W-1:0]  s_wr_data_o,
    output logic [NUM_S*ADDR_W-1:0]  s_rd_addr_o,
    input  logic [NUM_S*DATA_W-1:0]  s_rd_data_i
);

    localparam int GNT_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [GNT_W-1:0] LAST_RST = GNT_W'(NUM_M - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(MAX_BURST - 1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [GNT_W-1:0] grant_q;
    logic [GNT_W-1:0] grant_d;
    logic [GNT_W-1:0] last_q;
    logic [GNT_W-1:0] last_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [NUM_M-1:0]  g_onehot;
    logic              g_req;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    logic              active;
    logic [SEL_W-1:0]  sel;
    logic              sel_ok;
    logic [NUM_S-1:0]  s_hit;
    logic [DATA_W-1:0] rd_word;
    logic [NUM_M-1:0]  ack;

    logic [GNT_W-1:0]  arb_base;
    logic [NUM_M-1:0]  arb_mask;
    logic              arb_found;
    logic [GNT_W-1:0]  arb_pick;

    logic              others;
    logic              at_cap;
    logic              rel;

    // Decode the grant register into a one-hot master select
    always_comb begin
        g_onehot = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == GNT_W'(i)) begin
                g_onehot[i] = 1'b1;
            end
        end
    end

    // Mux out the granted master's live request fields
    always_comb begin
        g_req   = 1'b0;
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (g_onehot[i]) begin
                g_req   = m_req_i[i];
                g_we    = m_we_i[i];
                g_addr  = m_addr_i[i*ADDR_W +: ADDR_W];
                g_wdata = m_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Address decode: top SEL_W bits pick the slave, out of range is an error
    always_comb begin
        active = (state_q == BUSY) && g_req;
        sel    = g_addr[ADDR_W-1 -: SEL_W];
        sel_ok = int'(sel) < NUM_S;
        s_hit  = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (active && sel_ok && (int'(sel) == k)) begin
                s_hit[k] = 1'b1;
            end
        end
    end

    // Slave-side strobes; only the addressed slave sees non-zero values
    always_comb begin
        s_wr_en_o   = '0;
        s_wr_addr_o = '0;
        s_wr_data_o = '0;
        s_rd_addr_o = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (s_hit[k]) begin
                if (g_we) begin
                    s_wr_en_o[k]                   = 1'b1;
                    s_wr_addr_o[k*ADDR_W +: ADDR_W] = g_addr;
                    s_wr_data_o[k*DATA_W +: DATA_W] = g_wdata;
                end else begin
                    s_rd_addr_o[k*ADDR_W +: ADDR_W] = g_addr;
                end
            end
        end
    end

    // Pick the read word returned by the addressed slave
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (s_hit[k] && !g_we) begin
                rd_word = s_rd_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Master-side ack, error, read data and hold
    always_comb begin
        ack       = active ? g_onehot : '0;
        m_ack_o   = ack;
        m_err_o   = (active && !sel_ok) ? g_onehot : '0;
        m_hold_o  = m_req_i & ~ack;
        m_rdata_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (ack[i]) begin
                m_rdata_o[i*DATA_W +: DATA_W] = rd_word;
            end
        end
    end

    // Candidate set: in BUSY the current owner is excluded and scan starts after it
    always_comb begin
        if (state_q == BUSY) begin
            arb_base = grant_q;
            arb_mask = m_req_i & ~g_onehot;
        end else begin
            arb_base = last_q;
            arb_mask = m_req_i;
        end
    end

    // Rotating priority: first requester after arb_base, wrapping modulo NUM_M
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (!arb_found && arb_mask[i] &&
                    (((int'(arb_base) + k) % NUM_M) == i)) begin
                    arb_found = 1'b1;
                    arb_pick  = GNT_W'(i);
                end
            end
        end
    end

    // Release when the owner drops req, or on its capped beat if anyone waits
    always_comb begin
        others = |(m_req_i & ~g_onehot);
        at_cap = cnt_q >= CNT_CAP;
        rel    = (state_q == BUSY) && (!g_req || (at_cap && others));
    end

    // Next-state logic for grant, rotation pointer and burst counter
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BUSY;
                    grant_d = arb_pick;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    last_d = grant_q;
                    cnt_d  = '0;
                    if (arb_found) begin
                        grant_d = arb_pick;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb_rib_rr_arbiter: directed cases plus randomized traffic
// checked every cycle against a round-robin reference model.
module tb_rib_rr_arbiter;

    localparam int NM    = 3;
    localparam int NS    = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int MB    = 8;
    localparam int BOUND = (NM - 1) * MB + NM;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*DW-1:0] m_rdata;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic [NM-1:0]    m_hold;
    logic [NS-1:0]    s_wr_en;
    logic [NS*AW-1:0] s_wr_addr;
    logic [NS*DW-1:0] s_wr_data;
    logic [NS*AW-1:0] s_rd_addr;
    logic [NS*DW-1:0] s_rd_data;

    int total = 0;
    int bad   = 0;

    bit mbusy = 1'b0;
    int mg    = 0;
    int mcnt  = 0;
    int mlast = NM - 1;

    int wait_c[NM];
    int wait_max[NM];
    int order[$];

    rib_rr_arbiter #(
        .NUM_M(NM), .NUM_S(NS), .ADDR_W(AW),
        .DATA_W(DW), .SEL_W(SW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(m_req), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata), .m_ack_o(m_ack),
        .m_err_o(m_err), .m_hold_o(m_hold),
        .s_wr_en_o(s_wr_en), .s_wr_addr_o(s_wr_addr),
        .s_wr_data_o(s_wr_data), .s_rd_addr_o(s_rd_addr),
        .s_rd_data_i(s_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] slave_word(input int k,
                                                 input logic [AW-1:0] a);
        logic [DW-1:0] salt;
        salt = DW'(32'h9E37_79B9 ^ (k * 32'h0101_0101));
        return DW'(a) ^ salt;
    endfunction

    // Slaves answer combinationally from their read address
    always_comb begin
        s_rd_data = '0;
        for (int k = 0; k < NS; k++) begin
            s_rd_data[k*DW +: DW] = slave_word(k, s_rd_addr[k*AW +: AW]);
        end
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Nearest requester after ptr, measured as circular distance
    function automatic int rr_pick(input logic [NM-1:0] req, input int ptr);
        int best;
        int bestd;
        best  = -1;
        bestd = NM;
        for (int i = 0; i < NM; i++) begin
            int d;
            d = (i - ptr - 1 + 2 * NM) % NM;
            if (req[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_step();
        logic [NM-1:0] rest;
        if (!mbusy) begin
            if (m_req != '0) begin
                mg    = rr_pick(m_req, mlast);
                mbusy = 1'b1;
                mcnt  = 0;
            end
        end else begin
            rest     = m_req;
            rest[mg] = 1'b0;
            if (!m_req[mg] || (mcnt + 1 >= MB && rest != '0)) begin
                mlast = mg;
                mcnt  = 0;
                if (rest != '0) mg = rr_pick(rest, mlast);
                else mbusy = 1'b0;
            end else if (mcnt < MB) begin
                mcnt++;
            end
        end
    endtask

    task automatic check_cycle();
        logic [NM-1:0]    e_ack;
        logic [NM-1:0]    e_err;
        logic [NM-1:0]    e_hold;
        logic [NM*DW-1:0] e_rd;
        logic [NS-1:0]    e_wen;
        logic [NS*AW-1:0] e_wa;
        logic [NS*DW-1:0] e_wd;
        logic [NS*AW-1:0] e_ra;
        logic [AW-1:0]    a;
        int               sel;
        e_ack = '0; e_err = '0; e_rd = '0;
        e_wen = '0; e_wa = '0; e_wd = '0; e_ra = '0;
        if (mbusy && m_req[mg]) begin
            a   = m_addr[mg*AW +: AW];
            sel = int'(a[AW-1 -: SW]);
            e_ack[mg] = 1'b1;
            if (sel >= NS) begin
                e_err[mg] = 1'b1;
            end else if (m_we[mg]) begin
                e_wen[sel]         = 1'b1;
                e_wa[sel*AW +: AW] = a;
                e_wd[sel*DW +: DW] = m_wdata[mg*DW +: DW];
            end else begin
                e_ra[sel*AW +: AW] = a;
                e_rd[mg*DW +: DW]  = slave_word(sel, a);
            end
        end
        e_hold = m_req & ~e_ack;
        chk("ack", m_ack, e_ack);
        chk("err", m_err, e_err);
        chk("hold", m_hold, e_hold);
        chk("rdata", m_rdata, e_rd);
        chk("wr_en", s_wr_en, e_wen);
        chk("wr_addr", s_wr_addr, e_wa);
        chk("wr_data", s_wr_data, e_wd);
        chk("rd_addr", s_rd_addr, e_ra);
        for (int i = 0; i < NM; i++) begin
            if (rst_n && e_hold[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > wait_max[i]) wait_max[i] = wait_c[i];
        end
    endtask

    // Reference model advances on each edge, resets with the DUT
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mbusy = 1'b0;
                mg    = 0;
                mcnt  = 0;
                mlast = NM - 1;
            end else begin
                model_step();
            end
        end
    end

    // Compare DUT against the model mid-cycle
    initial begin
        for (int i = 0; i < NM; i++) begin
            wait_c[i]   = 0;
            wait_max[i] = 0;
        end
        forever begin
            @(negedge clk);
            check_cycle();
        end
    end

    task automatic set_m(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        m_req = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_fields(input int i);
        int r;
        logic [3:0] s;
        r = $urandom_range(0, 9);
        if (r < 8) s = 4'(r % NS);
        else if (r == 8) s = 4'(NS);
        else s = 4'hF;
        m_we[i] = 1'($urandom_range(0, 1));
        set_m(i, {s, 28'($urandom)}, DW'($urandom));
    endtask

    initial begin
        logic [NM-1:0] seen;
        int n;
        bit got;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", m_ack, 0);
        chk("rst_wr_en", s_wr_en, 0);
        chk("rst_hold", m_hold, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single write from master 0 to slave 1
        m_req = 3'b001;
        m_we  = 3'b001;
        set_m(0, 32'h1000_0004, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_hold_c1", m_hold, 3'b001);
        chk("t1_ack_c1", m_ack, 0);
        @(negedge clk);
        chk("t1_ack_c2", m_ack, 3'b001);
        chk("t1_wr_en", s_wr_en, 4'b0010);
        chk("t1_wr_data", s_wr_data[DW +: DW], 32'hDEAD_BEEF);
        chk("t1_wr_addr", s_wr_addr[AW +: AW], 32'h1000_0004);
        @(posedge clk);
        #1;
        m_req = '0;
        m_we  = '0;
        repeat (2) @(posedge clk);
        #1;

        // three simultaneous reads from reset: served 0,1,2
        do_reset();
        for (int i = 0; i < NM; i++) begin
            set_m(i, (32'(i) << 28) | 32'h0000_0100 | 32'(i * 4), '0);
        end
        m_we  = '0;
        m_req = '1;
        order.delete();
        @(negedge clk);
        chk("t2_hold_all", m_hold, 3'b111);
        @(posedge clk);
        #1;
        for (int c = 0; c < 20 && order.size() < 3; c++) begin
            @(negedge clk);
            seen = m_ack;
            for (int i = 0; i < NM; i++) begin
                if (seen[i]) order.push_back(i);
            end
            @(posedge clk);
            #1;
            m_req = m_req & ~seen;
        end
        chk("t2_count", order.size(), 3);
        for (int k = 0; k < order.size(); k++) begin
            chk($sformatf("t2_order%0d", k), order[k], k);
        end
        m_req = '0;
        repeat (2) @(posedge clk);
        #1;

        // master 1 streams writes; master 0 joins and forces a rotation
        m_req[1] = 1'b1;
        m_we[1]  = 1'b1;
        set_m(1, 32'h2000_0000, 32'h1111_0000);
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (m_ack[1]) n++;
            if (m_ack[0]) got = 1'b1;
            @(posedge clk);
            #1;
            if (c == 2) begin
                m_req[0] = 1'b1;
                m_we[0]  = 1'b0;
                set_m(0, 32'h0000_0040, '0);
            end
            if (got) m_req[0] = 1'b0;
            set_m(1, 32'h2000_0000 + 32'(c * 4), 32'h1111_0000 + 32'(c));
        end
        chk("t3_m0_granted", got, 1);
        chk("t3_m1_burst", n, MB);
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (m_ack[1]) got = 1'b1;
        end
        chk("t3_m1_regrant", got, 1);
        n = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (m_ack[1]) n++;
        end
        chk("t3_m1_alone", n, 24);
        @(posedge clk);
        #1;
        m_req = '0;
        m_we  = '0;
        repeat (3) @(posedge clk);
        #1;

        // read from an unmapped slave index
        m_req = 3'b001;
        set_m(0, 32'hF000_0000, '0);
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (m_ack[0]) begin
                got = 1'b1;
                chk("t4_ack", m_ack, 3'b001);
                chk("t4_err", m_err, 3'b001);
                chk("t4_rdata", m_rdata[0 +: DW], 0);
                chk("t4_wr_en", s_wr_en, 0);
                chk("t4_rd_addr", s_rd_addr, 0);
            end
        end
        chk("t4_ack_seen", got, 1);
        @(posedge clk);
        #1;
        m_req = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a write burst
        m_req = 3'b001;
        m_we  = 3'b001;
        set_m(0, 32'h3000_0010, 32'h5555_AAAA);
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (m_ack[0]) got = 1'b1;
        end
        chk("t5_ack_seen", got, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en_async", s_wr_en, 0);
        chk("t5_ack_async", m_ack, 0);
        m_we  = '0;
        m_req = 3'b111;
        for (int i = 0; i < NM; i++) set_m(i, 32'(i) << 28, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_arb_cycle", m_ack, 0);
        @(negedge clk);
        chk("t5_first_tie", m_ack, 3'b001);
        @(posedge clk);
        #1;
        m_req = '0;
        repeat (3) @(posedge clk);
        #1;

        // randomized traffic at several load levels
        for (int ph = 0; ph < 3; ph++) begin
            int p;
            p = (ph == 0) ? 50 : ((ph == 1) ? 92 : 25);
            for (int c = 0; c < 700; c++) begin
                @(negedge clk);
                seen = m_ack;
                @(posedge clk);
                #1;
                for (int i = 0; i < NM; i++) begin
                    if (!m_req[i] || seen[i]) begin
                        m_req[i] = ($urandom_range(0, 99) < p);
                    end
                    rand_fields(i);
                end
            end
        end
        @(negedge clk);
        seen = m_ack;
        @(posedge clk);
        #1;
        m_req = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < NM; i++) begin
            chk($sformatf("wait_bound_m%0d", i), wait_max[i] <= BOUND, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
